// File: rtl/nfu_1_pipe.sv
// rtl/nfu_1_pipe.sv - pipelined Tn x Tn fixed-point multiplier array; NFU_PIPE_ROUND_EN selects round-half-up
module nfu_1_pipe #(
    parameter int BIT_WIDTH = 16,
    parameter int Q         = 10,
    parameter int Tn        = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic                          i_mode,
    input  logic [BIT_WIDTH*Tn*Tn-1:0]    i_inputs,
    input  logic [BIT_WIDTH*Tn*Tn-1:0]    i_synapses,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [BIT_WIDTH*Tn*Tn-1:0]    o_results,
    output logic                          o_sat
);
    localparam int LANES = Tn * Tn;
    localparam int PW    = 2 * BIT_WIDTH;
    localparam int EW    = PW + 1;

    localparam logic signed [EW-1:0] RES_MAX = {{(EW-BIT_WIDTH+1){1'b0}}, {(BIT_WIDTH-1){1'b1}}};
    localparam logic signed [EW-1:0] RES_MIN = {{(EW-BIT_WIDTH+1){1'b1}}, {(BIT_WIDTH-1){1'b0}}};
`ifdef NFU_PIPE_ROUND_EN
    localparam logic signed [EW-1:0] RND = EW'(1) << (Q-1);
`endif

    logic                      s1Valid;
    logic                      s2Valid;
    logic                      s1Load;
    logic                      s2Load;
    logic                      s2Sat;
    logic [LANES*PW-1:0]       prodNext;
    logic [LANES*PW-1:0]       s1Prod;
    logic [LANES*BIT_WIDTH-1:0] resNext;
    logic [LANES*BIT_WIDTH-1:0] s2Res;
    logic [LANES-1:0]          satLane;

    // Bubble-collapsing advance: a stage refills whenever its downstream neighbour moves.
    assign s2Load  = !s2Valid || i_ready;
    assign s1Load  = !s1Valid || s2Load;
    assign o_ready = s1Load;

    generate
        for (genvar k = 0; k < LANES; k++) begin : gLane
            logic [BIT_WIDTH-1:0]    opA;
            logic [BIT_WIDTH-1:0]    opB;
            logic signed [EW-1:0]    pExt;
            logic signed [EW-1:0]    scaled;
            logic [BIT_WIDTH-1:0]    laneRes;
            logic                    laneSat;

            assign opB = i_synapses[k*BIT_WIDTH +: BIT_WIDTH];
            assign opA = i_mode ? i_inputs[k*BIT_WIDTH +: BIT_WIDTH]
                                : i_inputs[(k/Tn)*BIT_WIDTH +: BIT_WIDTH];

            assign prodNext[k*PW +: PW] = $signed({{BIT_WIDTH{opA[BIT_WIDTH-1]}}, opA})
                                        * $signed({{BIT_WIDTH{opB[BIT_WIDTH-1]}}, opB});

            // One extra bit of headroom keeps the rounding add from wrapping.
`ifdef NFU_PIPE_ROUND_EN
            assign pExt = $signed({s1Prod[k*PW+PW-1], s1Prod[k*PW +: PW]}) + RND;
`else
            assign pExt = $signed({s1Prod[k*PW+PW-1], s1Prod[k*PW +: PW]});
`endif
            assign scaled = pExt >>> Q;

            always_comb begin
                laneRes = scaled[BIT_WIDTH-1:0];
                laneSat = 1'b0;
                if (scaled > RES_MAX) begin
                    laneRes = {1'b0, {(BIT_WIDTH-1){1'b1}}};
                    laneSat = 1'b1;
                end else if (scaled < RES_MIN) begin
                    laneRes = {1'b1, {(BIT_WIDTH-1){1'b0}}};
                    laneSat = 1'b1;
                end
            end

            assign resNext[k*BIT_WIDTH +: BIT_WIDTH] = laneRes;
            assign satLane[k] = laneSat;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            s1Valid <= 1'b0;
            s2Valid <= 1'b0;
            s1Prod  <= '0;
            s2Res   <= '0;
            s2Sat   <= 1'b0;
        end else begin
            if (s1Load) begin
                s1Valid <= i_valid;
                if (i_valid) begin
                    s1Prod <= prodNext;
                end
            end
            if (s2Load) begin
                s2Valid <= s1Valid;
                s2Sat   <= s1Valid && (|satLane);
                if (s1Valid) begin
                    s2Res <= resNext;
                end
            end
        end
    end

    assign o_valid   = s2Valid;
    assign o_results = s2Res;
    assign o_sat     = s2Sat;

endmodule

// File: doc/nfu_1_pipe.md
Name: nfu_1_pipe

Overview:
Parametrised, pipelined successor to the NFU-1 multiplier array. It multiplies a Tn x Tn synapse matrix by neuron inputs in signed Q-format fixed point, with a run-time mode:
- broadcast: one input per row, shared across Tn synapses;
- elementwise: one input per synapse.

It adds round/saturate arithmetic, a two-stage pipeline with valid/ready handshake and backpressure, and a saturation flag. It sits between the NBin/SB buffers and the NFU-2 adder trees.

Parameters:
- BIT_WIDTH, 16, operand and result width (signed two's complement), >= 4
- Q, 10, fractional bits; 1 <= Q <= BIT_WIDTH-2
- Tn, 16, rows and columns of the array; lane count = Tn*Tn

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- i_valid  in  1  input beat valid
- o_ready  out  1  block can accept an input beat this cycle
- i_mode  in  1  0 = broadcast, 1 = elementwise; sampled with the beat
- i_inputs  in  BIT_WIDTH*Tn*Tn  input operands; lane k = bits [(k+1)*BIT_WIDTH-1 : k*BIT_WIDTH]
- i_synapses  in  BIT_WIDTH*Tn*Tn  synapse matrix, row-major; lane k = row k/Tn, column k%Tn
- o_valid  out  1  output beat valid
- i_ready  in  1  downstream accepts the output beat
- o_results  out  BIT_WIDTH*Tn*Tn  products, same lane layout as i_synapses
- o_sat  out  1  at least one lane of the current output beat saturated

Behaviour:
Reset:
- rst=1 at a clock edge clears both stage valid bits: o_valid=0, o_results=0, o_sat=0.
- o_ready=1 from the first cycle after reset.
- A reset mid-operation discards all in-flight beats; nothing is emitted afterwards.

Handshake:
- An input transfer occurs when i_valid && o_ready.
- An output transfer occurs when o_valid && i_ready.
- o_valid, o_results and o_sat are held stable while o_valid && !i_ready.

Pipeline:
- S1 registers the full 2*BIT_WIDTH signed product per lane, plus a mode-independent valid bit.
- S2 registers the scaled, rounded and saturated result, the per-beat o_sat and the valid bit.
- Latency is 2 cycles from input transfer to o_valid when there is no backpressure; sustained throughput is 1 beat/cycle.

Stage advance (bubble-collapsing):
- S2 loads when it is empty or its output transfers this cycle.
- S1 loads when it is empty or S2 loads this cycle.
- o_ready = S1 empty || S2 loads; combinational from i_ready, with no path from i_valid.
- Simultaneous input and output transfer in one cycle is supported with no bubble.
- With both stages full and i_ready=0: o_ready=0 and no data is lost.

Operand selection, lane k:
- B = synapse lane k.
- A = i_inputs lane (k/Tn) when i_mode=0. Only lanes 0..Tn-1 of i_inputs are used; the upper lanes are ignored.
- A = i_inputs lane k when i_mode=1.

Arithmetic, per lane:
- P = A*B as a signed 2*BIT_WIDTH-bit value.
- R = (P + RND) >>> Q, arithmetic shift, where RND is defined by the optional feature.
- If R > 2^(BIT_WIDTH-1)-1, the result is 0x7FF..F. If R < -2^(BIT_WIDTH-1), the result is 0x800..0. Either case marks that lane saturated.
- The rounding addition is done at 2*BIT_WIDTH+1 bits so it cannot wrap.
- o_sat is the OR of the lane saturation bits of the beat in S2.

Optional Feature:
NFU_PIPE_ROUND_EN
- Defined: RND = 1 << (Q-1), i.e. round-half-up to nearest.
- Undefined: RND = 0, i.e. truncation toward negative infinity. No rounding adder is instantiated.
- Latency, handshake and saturation are identical in both builds.

Test Plan:
All values use defaults (BIT_WIDTH=16, Q=10).
1. Elementwise, all lanes A=0x0600 (1.5), B=0x0800 (2.0), single beat, i_ready=1 -> o_valid exactly 2 cycles later; all lanes 0x0C00; o_sat=0; o_valid=0 the following cycle.
2. Elementwise, lane 0: A=0xFC00 (-1.0), B=0x0600; lane 1: A=0x7FFF, B=0x7FFF; lane 2: A=0x8000, B=0x7FFF -> 0xFA00, 0x7FFF, 0x8000 respectively; o_sat=1.
3. Elementwise, A=0x0001, B=0x0200 -> 0x0001 with NFU_PIPE_ROUND_EN defined, 0x0000 without; A=0xFFFF, B=0x0200 -> 0x0000 with, 0xFFFF without.
4. Broadcast, input lane r = r+1 in Q10 (0x0400*(r+1)), all synapses 0x0400 -> every lane in row r = 0x0400*(r+1); upper i_inputs lanes set to 0x7FFF have no effect.
5. Stream 8 beats with i_valid=1 and i_ready toggling 1,0,0,1,... -> all 8 results delivered in order, none dropped or duplicated, outputs stable while stalled; o_ready=0 only when both stages are full and i_ready=0.
6. Two beats in flight, assert rst for 1 cycle -> o_valid=0, o_results=0 and o_ready=1 the next cycle; neither in-flight beat ever appears.
